// File: rtl/q_device_responder_pkg.sv
// q_chan_pkg: shared Q-channel definitions.
//   q_state_e           - responder FSM state encoding (3 bits, exposed on the
//                         'state' debug port of q_device_responder).
//   Q_IDLE_WAIT_DEF     - default consecutive idle cycles before accepting.
//   Q_DENY_TIMEOUT_DEF  - default cycles in REQUEST before denying.
//   Q_SYNC_STAGES       - request synchronizer depth when Q_RESP_SYNC_EN is set.
package q_chan_pkg;

  typedef enum logic [2:0] {
    Q_RUN      = 3'd0,
    Q_REQUEST  = 3'd1,
    Q_STOPPED  = 3'd2,
    Q_EXIT     = 3'd3,
    Q_DENIED   = 3'd4,
    Q_CONTINUE = 3'd5
  } q_state_e;

  localparam int Q_IDLE_WAIT_DEF    = 4;
  localparam int Q_DENY_TIMEOUT_DEF = 32;
  localparam int Q_SYNC_STAGES      = 2;

endpackage

// File: rtl/q_device_responder_sync2.sv
// q_sync2: generic two-flop synchronizer with a parameterized reset value.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset (flops load RESET_VAL)
//   d        in  asynchronous input
//   q        out synchronized output (two clk edges of latency)
module q_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/q_device_responder.sv
// q_device_responder: device-side Q-channel responder. Answers the power
// controller's quiescence request (qreqn) with an accept (qacceptn low) once
// the device has been idle for IDLE_WAIT consecutive cycles, or a denial
// (qdeny) on a wake request or after DENY_TIMEOUT cycles in REQUEST.
// Optional build macro: Q_RESP_SYNC_EN - qreqn passes through a two-flop
// synchronizer (adds 2 cycles of request/exit latency). Undefined: qreqn is
// assumed synchronous to clk and used directly.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   qreqn          controller quiescence request, active-low
//   dev_busy       device has outstanding work
//   wake_req       device wants to stay/become powered
//   qacceptn       quiescence accept, active-low
//   qdeny          quiescence denial
//   qactive        registered (dev_busy | wake_req)
//   quiesce        device must stop taking new work (REQUEST, STOPPED)
//   stopped        clocks/power may be removed (STOPPED)
//   proto_err      sticky controller protocol violation flag
//   state          current FSM state (debug, q_state_e encoding)
// Handshake: qreqn/qacceptn/qdeny follow the four-phase Q-channel protocol;
// qreqn may only rise once qacceptn is low or qdeny is high, and may only fall
// again once qacceptn is back high and qdeny is back low.
module q_device_responder
  import q_chan_pkg::*;
#(
  parameter int IDLE_WAIT    = Q_IDLE_WAIT_DEF,
  parameter int DENY_TIMEOUT = Q_DENY_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       qreqn,
  input  logic       dev_busy,
  input  logic       wake_req,
  output logic       qacceptn,
  output logic       qdeny,
  output logic       qactive,
  output logic       quiesce,
  output logic       stopped,
  output logic       proto_err,
  output logic [2:0] state
);

  localparam int CW = $clog2(DENY_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(DENY_TIMEOUT - 1);

  logic qreqn_s;

`ifdef Q_RESP_SYNC_EN
  q_sync2 #(
    .RESET_VAL (1'b1)
  ) u_qreqn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (qreqn),
    .q       (qreqn_s)
  );
`else
  assign qreqn_s = qreqn;
`endif

  q_state_e      state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          proto_err_q, proto_err_d;
  logic          qactive_q, qactive_d;
  logic          dev_idle;

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  assign dev_idle = !dev_busy && !wake_req;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    to_cnt_d    = to_cnt_q;
    proto_err_d = proto_err_q;
    qactive_d   = dev_busy | wake_req;
    case (state_q)
      Q_RUN: begin
        if (!qreqn_s) begin
          state_d    = Q_REQUEST;
          idle_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      Q_REQUEST: begin
        idle_cnt_d = dev_idle ? sat_inc(idle_cnt_q) : '0;
        to_cnt_d   = sat_inc(to_cnt_q);
        // A withdrawn request here is illegal; flag it and do not accept.
        // Only a deny (wake or timeout) may still leave REQUEST.
        if (qreqn_s) begin
          proto_err_d = 1'b1;
        end
        if (dev_idle && (idle_cnt_q == IDLE_LAST) && !qreqn_s) begin
          state_d = Q_STOPPED;
        end else if (wake_req) begin
          state_d = Q_DENIED;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = Q_DENIED;
        end
      end
      Q_STOPPED: begin
        if (qreqn_s) begin
          state_d = Q_EXIT;
        end
      end
      Q_EXIT: begin
        if (!qreqn_s) begin
          proto_err_d = 1'b1;
        end
        state_d = Q_RUN;
      end
      Q_DENIED: begin
        if (qreqn_s) begin
          state_d = Q_CONTINUE;
        end
      end
      Q_CONTINUE: begin
        if (!qreqn_s) begin
          proto_err_d = 1'b1;
        end
        state_d = Q_RUN;
      end
      default: begin
        state_d = Q_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= Q_RUN;
      idle_cnt_q  <= '0;
      to_cnt_q    <= '0;
      proto_err_q <= 1'b0;
      qactive_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      to_cnt_q    <= to_cnt_d;
      proto_err_q <= proto_err_d;
      qactive_q   <= qactive_d;
    end
  end

  // All outputs decode registered state only.
  assign qacceptn  = !((state_q == Q_STOPPED) || (state_q == Q_EXIT));
  assign qdeny     = (state_q == Q_DENIED) || (state_q == Q_CONTINUE);
  assign quiesce   = (state_q == Q_REQUEST) || (state_q == Q_STOPPED);
  assign stopped   = (state_q == Q_STOPPED);
  assign qactive   = qactive_q;
  assign proto_err = proto_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_q_device_responder.sv
// Testbench for q_device_responder: reset, table-driven accept handshakes,
// and hand-written timeout / wake / protocol / async-reset sequences.
// Works in both builds; Q_RESP_SYNC_EN adds LAT edges where qreqn changes.
module tb_q_device_responder;
  import q_chan_pkg::*;

  localparam int IW = 4;
  localparam int DT = 32;
`ifdef Q_RESP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int W = 9;

  logic       clk;
  logic       reset_n;
  logic       qreqn;
  logic       dev_busy;
  logic       wake_req;
  logic       qacceptn;
  logic       qdeny;
  logic       qactive;
  logic       quiesce;
  logic       stopped;
  logic       proto_err;
  logic [2:0] state;

  q_device_responder #(
    .IDLE_WAIT    (IW),
    .DENY_TIMEOUT (DT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .qreqn     (qreqn),
    .dev_busy  (dev_busy),
    .wake_req  (wake_req),
    .qacceptn  (qacceptn),
    .qdeny     (qdeny),
    .qactive   (qactive),
    .quiesce   (quiesce),
    .stopped   (stopped),
    .proto_err (proto_err),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         qreqn;
    logic         busy;
    logic         wake;
    int           edges;
    bit           add_lat;
    logic [W-1:0] exp;
  } vec_t;

  function automatic logic [W-1:0] mk(input q_state_e st, input logic qa, input logic qd,
                                      input logic qact, input logic qui, input logic stp,
                                      input logic err);
    return {st, qa, qd, qact, qui, stp, err};
  endfunction

  function automatic logic [W-1:0] obs();
    return {state, qacceptn, qdeny, qactive, quiesce, stopped, proto_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic b, input logic w);
    qreqn    = r;
    dev_busy = b;
    wake_req = w;
  endtask

  // Drop qreqn and wait (bounded) for REQUEST; entry must take 1+LAT edges.
  task automatic enter_request(input string name);
    int k;
    qreqn = 1'b0;
    k = 0;
    do begin
      step(1);
      k++;
    end while (state != Q_REQUEST && k < 10);
    check({name, "_enter_state"}, state, Q_REQUEST);
    check({name, "_enter_lat"}, k, 1 + LAT);
  endtask

  vec_t vecs[14];

  initial begin
    vec_t  v;
    logic [W-1:0] e;
    int    k;

    // Accept handshake, then accept with a one-cycle busy pulse.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, mk(Q_RUN,     1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, mk(Q_REQUEST, 1, 0, 0, 1, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 3, 1'b0, mk(Q_REQUEST, 1, 0, 0, 1, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, mk(Q_STOPPED, 0, 0, 0, 1, 1, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 5, 1'b0, mk(Q_STOPPED, 0, 0, 0, 1, 1, 0)};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, mk(Q_EXIT,    0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, mk(Q_RUN,     1, 0, 0, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, mk(Q_REQUEST, 1, 0, 0, 1, 0, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, mk(Q_REQUEST, 1, 0, 0, 1, 0, 0)};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, mk(Q_REQUEST, 1, 0, 1, 1, 0, 0)};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, mk(Q_REQUEST, 1, 0, 0, 1, 0, 0)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, mk(Q_STOPPED, 0, 0, 0, 1, 1, 0)};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, mk(Q_EXIT,    0, 0, 0, 0, 0, 0)};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, mk(Q_RUN,     1, 0, 0, 0, 0, 0)};

    // ---- reset with request already asserted ----
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    step(3);
    check("rst_state", state, Q_RUN);
    check("rst_qacceptn", qacceptn, 1'b1);
    check("rst_qdeny", qdeny, 1'b0);
    check("rst_qactive", qactive, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    reset_n = 1'b1;
    enter_request("rst_release");
    reset_n = 1'b0;
    qreqn = 1'b1;
    #1;
    check("rst_async_run", state, Q_RUN);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);

    // ---- table-driven handshakes ----
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      drive(v.qreqn, v.busy, v.wake);
      step(v.edges + (v.add_lat ? LAT : 0));
      exp_q.push_back(v.exp);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), obs(), e);
    end

    // ---- timeout deny ----
    drive(1'b1, 1'b1, 1'b0);
    enter_request("to");
    step(DT - 1);
    check("to_before", obs(), mk(Q_REQUEST, 1, 0, 1, 1, 0, 0));
    step(1);
    check("to_denied", obs(), mk(Q_DENIED, 1, 1, 1, 0, 0, 0));
    qreqn = 1'b1;
    step(1 + LAT);
    check("to_continue", obs(), mk(Q_CONTINUE, 1, 1, 1, 0, 0, 0));
    dev_busy = 1'b0;
    step(1);
    check("to_run", obs(), mk(Q_RUN, 1, 0, 0, 0, 0, 0));

    // ---- wake_req deny in REQUEST cycle 3 ----
    enter_request("wake");
    step(2);
    wake_req = 1'b1;
    step(1);
    check("wake_denied", obs(), mk(Q_DENIED, 1, 1, 1, 0, 0, 0));
    wake_req = 1'b0;
    qreqn = 1'b1;
    step(1 + LAT);
    check("wake_continue", state, Q_CONTINUE);
    step(1);
    check("wake_run", obs(), mk(Q_RUN, 1, 0, 0, 0, 0, 0));

    // ---- reset asserted in STOPPED ----
    enter_request("rst_stop");
    step(IW);
    check("rst_stop_stopped", state, Q_STOPPED);
    #2 reset_n = 1'b0;
    #1;
    check("rst_stop_async", obs(), mk(Q_RUN, 1, 0, 0, 0, 0, 0));
    qreqn = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check("rst_stop_run", state, Q_RUN);

    // ---- protocol violation: request withdrawn in REQUEST ----
    dev_busy = 1'b1;
    enter_request("proto");
    step(2);
    qreqn = 1'b1;
    step(1 + LAT);
    check("proto_set", obs(), mk(Q_REQUEST, 1, 0, 1, 1, 0, 1));
    qreqn = 1'b0;
    step(3);
    check("proto_sticky", obs(), mk(Q_REQUEST, 1, 0, 1, 1, 0, 1));
    k = 0;
    while (state != Q_DENIED && k < 40) begin
      step(1);
      k++;
    end
    check("proto_denied", state, Q_DENIED);
    qreqn = 1'b1;
    dev_busy = 1'b0;
    step(1 + LAT);
    check("proto_continue", state, Q_CONTINUE);
    step(1);
    check("proto_run", obs(), mk(Q_RUN, 1, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/q_device_responder.md
# q_device_responder

Device-side Q-channel responder: the end of the Q-channel handshake that answers the power controller's quiescence requests. It samples QREQn, waits for the local device to go idle, and either accepts with QACCEPTn or refuses with QDENY. It also reports device activity on QACTIVE so that a denied controller, after its retry cooldown, can decide whether to request again. One instance sits at each power-gateable device boundary.

## Interface
- IDLE_WAIT, 4: consecutive idle cycles required in REQUEST before accepting; must be ≥1.
- DENY_TIMEOUT, 32: maximum cycles spent in REQUEST before denying; must be >IDLE_WAIT.
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- qreqn  in  1  controller quiescence request, active-low; asynchronous to clk.
- dev_busy  in  1  device has outstanding work.
- wake_req  in  1  device requests to stay or become powered.
- qacceptn  out  1  quiescence accept, active-low.
- qdeny  out  1  quiescence denial.
- qactive  out  1  registered (dev_busy | wake_req).
- quiesce  out  1  tells the device to stop taking new work; high in REQUEST and STOPPED.
- stopped  out  1  high in STOPPED; clocks and power may be removed.
- proto_err  out  1  sticky flag for controller protocol violations.
- state  out  3  current FSM state (debug).

## Operation
- The FSM runs on qreqn_s. This is the synchronized qreqn when the sync feature is enabled, and raw qreqn otherwise.
- All outputs are decoded from registers. There are no combinational paths from inputs to outputs.
- States and the outputs in each state (qacceptn/qdeny):
  - RUN: 1/0. When qreqn_s=0, go to REQUEST and clear idle_cnt and to_cnt.
  - REQUEST: 1/0, quiesce=1.
    - A cycle is idle when dev_busy=0 and wake_req=0. In an idle cycle, go to STOPPED if idle_cnt==IDLE_WAIT-1; otherwise increment idle_cnt. A non-idle cycle clears idle_cnt.
    - If wake_req=1, go to DENIED.
    - Otherwise, if to_cnt==DENY_TIMEOUT-1, go to DENIED. to_cnt increments every cycle spent in REQUEST.
    - Priority: accept > wake_req deny > timeout deny.
  - STOPPED: 0/0, quiesce=1, stopped=1. When qreqn_s=1, go to EXIT.
  - EXIT: 0/0. Always goes to RUN on the next edge.
  - DENIED: 1/1. When qreqn_s=1, go to CONTINUE.
  - CONTINUE: 1/1. Always goes to RUN on the next edge.
- Protocol violations:
  - qreqn_s=1 while in REQUEST sets proto_err. The state is held; only a timeout or deny exits REQUEST.
  - qreqn_s=0 in EXIT or CONTINUE sets proto_err. The transition to RUN still occurs.
- Counter widths are $clog2(DENY_TIMEOUT+1) bits. Counters saturate and never wrap.
- Reset values: state=RUN, qacceptn=1, qdeny=0, qactive=0, quiesce=0, stopped=0, proto_err=0, counters=0, synchronizer flops=1.
- Reset asserted mid-handshake, including in STOPPED, returns the block to RUN asynchronously.

## Timing
- Without sync: qreqn low before edge E means the state is REQUEST after edge E.
- With sync: 2 cycles are added, so the state is REQUEST after edge E+2.
- Device idle throughout REQUEST (entered at edge E): qacceptn=0 after edge E+IDLE_WAIT.
- Device busy throughout: qdeny=1 after edge E+DENY_TIMEOUT.
- wake_req=1 in the cycle after edge E+k: qdeny=1 after edge E+k+1.
- A REQUEST→STOPPED→EXIT→RUN exit takes 2 edges after qreqn_s=1. qacceptn returns to 1 on the second edge.
- qactive lags dev_busy | wake_req by 1 cycle.

## Configuration
- Q_RESP_SYNC_EN:
  - Defined: qreqn passes through a 2-flop synchronizer, reset to 1. This adds 2 cycles of request and exit latency.
  - Undefined: qreqn is used directly. The controller must then be synchronous to clk.

## Structure
- Package q_chan_pkg holds:
  - q_state_e enum, 3 bits: RUN=0, REQUEST=1, STOPPED=2, EXIT=3, DENIED=4, CONTINUE=5.
  - Shared Q-channel parameter defaults.
- Sub-module q_sync2: a generic 2-flop synchronizer with a parameterized reset value. It is instantiated only under Q_RESP_SYNC_EN.

## Test plan
- Reset: hold reset_n low with qreqn=0 → qacceptn=1, qdeny=0, qactive=0, state=RUN, proto_err=0. Release → state=REQUEST after the next edge (no sync).
- Idle accept (IDLE_WAIT=4, no sync): dev_busy=0, qreqn falls before edge 0 → qacceptn=0 after edge 4. qreqn rises before edge 10 → EXIT after edge 10, qacceptn=1 after edge 11.
- Busy pulse (IDLE_WAIT=4): REQUEST entered at edge 0, dev_busy=1 only in the cycle after edge 2 → qacceptn=0 after edge 7.
- Timeout deny (DENY_TIMEOUT=32): dev_busy=1 constant → qdeny=1 after edge 32 with qacceptn=1. qreqn rises → CONTINUE, then qdeny=0 one edge later.
- wake_req=1 at cycle 3 of REQUEST → DENIED after the following edge, qactive=1 one cycle after wake_req.
- Protocol/sync: qreqn rises in REQUEST → proto_err=1 and sticky, state held. With Q_RESP_SYNC_EN, repeat the idle-accept case → qacceptn=0 after edge 6.
